// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency load/store with misalignment error,
// pipeline stall output and a combinational debug read port.
module dmem_responder #(
  parameter int unsigned AW   = 8,
  parameter int unsigned WAIT = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          req_ready,
  output logic          stall,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_accept;
  logic            w_commit;

  logic            r_we;
  logic            r_mis;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_c_we;
  logic            w_c_mis;
  logic [AW-1:0]   w_c_idx;
  logic [31:0]     w_c_wdata;
  logic            w_unused;

  logic [31:0]     r_mem [DEPTH];

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (r_state == S_RESP) begin
          w_state_nxt = S_IDLE;
        end
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT == 0) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_cnt_nxt   = CW'(WAIT - 1);
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = CW'(r_cnt - CW'(1));
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With zero wait the commit happens on the accept edge, so use the live request
  always_comb begin
    w_c_we    = req_we;
    w_c_mis   = (req_addr[1:0] != 2'b00);
    w_c_idx   = req_addr[AW+1:2];
    w_c_wdata = req_wdata;
    if (r_state == S_BUSY) begin
      w_c_we    = r_we;
      w_c_mis   = r_mis;
      w_c_idx   = r_idx;
      w_c_wdata = r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_mis   <= (req_addr[1:0] != 2'b00);
        r_idx   <= req_addr[AW+1:2];
        r_wdata <= req_wdata;
      end
      if (w_commit) begin
        if (w_c_mis) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_rdata <= w_c_we ? 32'h0 : r_mem[w_c_idx];
          r_err   <= 1'b0;
        end
      end
    end
  end

  // Memory is never cleared; a reset on the commit edge drops the store
  always_ff @(posedge clk) begin
    if (clr && w_commit && w_c_we && !w_c_mis) begin
      r_mem[w_c_idx] <= w_c_wdata;
    end
  end

  assign req_ready = (r_state != S_BUSY);
  assign stall     = req_valid & ~req_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_data  = r_mem[dbg_addr];
  assign w_unused  = ^req_addr[31:AW+2];

endmodule
